// File: rtl/ipu_instr_decoder_pipe.sv
// ============================================================================
// ipu_instr_decoder_pipe : handshaked IPU instruction decoder, MLT scoreboard
// Revision 1.0
// ============================================================================
`default_nettype none

module ipu_instr_decoder_pipe #(
  parameter int AW      = 4,
  parameter int NB      = 4,
  parameter int MLT_LAT = 4,
  localparam int IW_W   = 2 + AW * (2 + NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW_W-1:0]   iw,
  input  logic              iw_valid,
  output logic              iw_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        dec_op,
  output logic [AW-1:0]     da,
  output logic [AW-1:0]     aa,
  output logic [NB*AW-1:0]  ab,
  output logic              dmx,
  output logic              muxd,
  output logic              rf_rw,
  output logic              rf_am,
  output logic              mm_en,
  output logic [1:0]        add_en,
  output logic              busy
);

  localparam int CW = $clog2(MLT_LAT + 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MLT = 2'b01,
    OP_MV  = 2'b10,
    OP_WT  = 2'b11
  } op_e;

  logic              valid_q, valid_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     da_q, da_d;
  logic [AW-1:0]     aa_q, aa_d;
  logic [NB*AW-1:0]  ab_q, ab_d;
  logic [6:0]        ctrl_q, ctrl_d;  // {dmx, mm_en, add_en[1:0], muxd, rf_rw, rf_am}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     lock_q, lock_d;

  logic [1:0]        w_op;
  logic [AW-1:0]     w_da;
  logic [AW-1:0]     w_aa;
  logic [NB*AW-1:0]  w_ab;
  logic [NB*AW-1:0]  w_ab_dec;
  logic [6:0]        w_ctrl_dec;
  logic              w_busy;
  logic              w_hit;
  logic              w_accept;

  always_comb begin
    w_op = iw[IW_W-1 -: 2];
    w_da = iw[IW_W-3 -: AW];
    w_aa = iw[IW_W-3-AW -: AW];
    // Slot 0 sits just below AA, so slot k counts down from the top of the B field.
    w_ab = '0;
    for (int k = 0; k < NB; k++) begin
      w_ab[k*AW +: AW] = iw[(NB-k)*AW-1 -: AW];
    end

    w_ctrl_dec = '0;
    w_ab_dec   = '0;
    case (op_e'(w_op))
      OP_ADD: begin
        w_ctrl_dec          = 7'b1001111;
        w_ab_dec[AW-1:0]    = w_ab[AW-1:0];
      end
      OP_MLT: begin
        w_ctrl_dec = 7'b0100010;
        w_ab_dec   = w_ab;
      end
      OP_MV:   w_ctrl_dec = 7'b1010110;
      default: w_ctrl_dec = 7'b0000000;
    endcase

    w_busy = (cnt_q != '0);
    w_hit  = (w_op == OP_MLT) || (w_aa == lock_q) ||
             ((w_da == lock_q) && (w_op != OP_WT));
    for (int k = 0; k < NB; k++) begin
      if (((w_op == OP_MLT) || ((w_op == OP_ADD) && (k == 0))) &&
          (w_ab[k*AW +: AW] == lock_q)) begin
        w_hit = 1'b1;
      end
    end

    iw_ready = (!valid_q || out_ready) && !(w_busy && w_hit);
    w_accept = iw_valid && iw_ready;
  end

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    da_d    = da_q;
    aa_d    = aa_q;
    ab_d    = ab_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;

    if (w_accept) begin
      valid_d = 1'b1;
      op_d    = w_op;
      da_d    = w_da;
      aa_d    = w_aa;
      ab_d    = w_ab_dec;
      ctrl_d  = w_ctrl_dec;
    end else if (valid_q && out_ready) begin
      // Addresses and opcode linger for debug; only the strobes must drop.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end

    if (w_accept && (w_op == OP_MLT)) begin
      cnt_d  = CW'(MLT_LAT);
      lock_d = w_da;
    end else if (w_busy) begin
      cnt_d  = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      da_q    <= '0;
      aa_q    <= '0;
      ab_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      lock_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      da_q    <= da_d;
      aa_q    <= aa_d;
      ab_q    <= ab_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign out_valid = valid_q;
  assign dec_op    = op_q;
  assign da        = da_q;
  assign aa        = aa_q;
  assign ab        = ab_q;
  assign dmx       = ctrl_q[6];
  assign mm_en     = ctrl_q[5];
  assign add_en    = ctrl_q[4:3];
  assign muxd      = ctrl_q[2];
  assign rf_rw     = ctrl_q[1];
  assign rf_am     = ctrl_q[0];
  assign busy      = (cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_ipu_instr_decoder_pipe.sv
// ============================================================================
// tb_ipu_instr_decoder_pipe : directed + random check against a cycle model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ipu_instr_decoder_pipe;

  localparam int AW      = 4;
  localparam int NB      = 4;
  localparam int MLT_LAT = 4;
  localparam int IW_W    = 2 + AW * (2 + NB);

  logic              clk = 1'b0;
  logic              rst;
  logic [IW_W-1:0]   iw;
  logic              iw_valid;
  logic              iw_ready;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        dec_op;
  logic [AW-1:0]     da;
  logic [AW-1:0]     aa;
  logic [NB*AW-1:0]  ab;
  logic              dmx, muxd, rf_rw, rf_am, mm_en, busy;
  logic [1:0]        add_en;

  ipu_instr_decoder_pipe #(.AW(AW), .NB(NB), .MLT_LAT(MLT_LAT)) dut (
    .clk(clk), .rst(rst), .iw(iw), .iw_valid(iw_valid), .iw_ready(iw_ready),
    .out_valid(out_valid), .out_ready(out_ready), .dec_op(dec_op), .da(da),
    .aa(aa), .ab(ab), .dmx(dmx), .muxd(muxd), .rf_rw(rf_rw), .rf_am(rf_am),
    .mm_en(mm_en), .add_en(add_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus fields
  logic [1:0]    s_op;
  logic [AW-1:0] s_da, s_aa;
  logic [AW-1:0] s_ab [NB];

  // Reference model state
  logic              m_valid;
  logic [1:0]        m_op;
  logic [AW-1:0]     m_da, m_aa, m_lock;
  logic [NB*AW-1:0]  m_ab;
  logic [6:0]        m_ctrl;
  int                m_cnt;
  logic              exp_ready;

  function automatic logic [6:0] ctrl_of(input logic [1:0] op);
    case (op)
      2'd0:    return 7'b1001111;
      2'd1:    return 7'b0100010;
      2'd2:    return 7'b1010110;
      default: return 7'b0000000;
    endcase
  endfunction

  // Registers an instruction reads, as a flag per candidate address
  function automatic logic conflicts(input logic [AW-1:0] lock);
    logic c;
    c = (s_op == 2'd1) || (s_aa == lock) || ((s_op != 2'd3) && (s_da == lock));
    if (s_op == 2'd0 && s_ab[0] == lock) c = 1'b1;
    if (s_op == 2'd1)
      for (int k = 0; k < NB; k++) if (s_ab[k] == lock) c = 1'b1;
    return c;
  endfunction

  function automatic logic [NB*AW-1:0] ab_expect();
    logic [NB*AW-1:0] e;
    e = '0;
    if (s_op == 2'd0) e[AW-1:0] = s_ab[0];
    if (s_op == 2'd1)
      for (int k = 0; k < NB; k++) e[k*AW +: AW] = s_ab[k];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_iw(input logic v, input logic [1:0] op, input logic [AW-1:0] d,
                        input logic [AW-1:0] a, input logic [AW-1:0] b0,
                        input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                        input logic [AW-1:0] b3);
    iw_valid = v;
    s_op = op; s_da = d; s_aa = a;
    s_ab[0] = b0; s_ab[1] = b1; s_ab[2] = b2; s_ab[3] = b3;
    iw = {op, d, a, b0, b1, b2, b3};
  endtask

  task automatic cycle();
    #1;
    exp_ready = (!m_valid || out_ready) && !((m_cnt > 0) && conflicts(m_lock));
    chk("iw_ready", {31'd0, iw_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_op = '0; m_da = '0; m_aa = '0; m_ab = '0;
      m_ctrl = '0; m_cnt = 0; m_lock = '0;
    end else begin
      if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (iw_valid && exp_ready) begin
        m_valid = 1'b1;
        m_op = s_op; m_da = s_da; m_aa = s_aa;
        m_ab = ab_expect();
        m_ctrl = ctrl_of(s_op);
        if (s_op == 2'd1) begin
          m_cnt = MLT_LAT;
          m_lock = s_da;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
        m_ctrl = '0;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
    chk("dec_op", {30'd0, dec_op}, {30'd0, m_op});
    chk("da", {28'd0, da}, {28'd0, m_da});
    chk("aa", {28'd0, aa}, {28'd0, m_aa});
    chk("ab", {16'd0, ab}, {16'd0, m_ab});
    chk("ctrl", {25'd0, dmx, mm_en, add_en, muxd, rf_rw, rf_am}, {25'd0, m_ctrl});
  endtask

  task automatic idle();
    set_iw(1'b0, 2'd0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    m_valid = 1'b0; m_op = '0; m_da = '0; m_aa = '0; m_ab = '0;
    m_ctrl = '0; m_cnt = 0; m_lock = '0; exp_ready = 1'b1;
    idle();

    // Reset
    cycle(); cycle();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;

    // ADD da3 aa1 ab0=2, then drain
    set_iw(1'b1, 2'd0, 4'd3, 4'd1, 4'd2, 4'hF, 4'hF, 4'hF);
    cycle();
    chk("add_ab", {16'd0, ab}, 32'h0002);
    chk("add_en", {30'd0, add_en}, 32'd1);
    idle(); cycle();
    chk("add_drain_add_en", {30'd0, add_en}, 32'd0);

    // MLT then dependent ADD reading r5
    set_iw(1'b1, 2'd1, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6);
    cycle();
    chk("mlt_mm_en", {31'd0, mm_en}, 32'd1);
    set_iw(1'b1, 2'd0, 4'd8, 4'd5, 4'd9, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("raw_still_stalled", {31'd0, out_valid}, 32'd0);
    cycle();
    chk("raw_accepted_da", {28'd0, da}, 32'd8);
    idle(); cycle();

    // MLT, independent MV (ab slots alias lock but are unused), then MLT to r7
    set_iw(1'b1, 2'd1, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6);
    cycle();
    set_iw(1'b1, 2'd2, 4'd2, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5);
    cycle();
    chk("mv_accepted_op", {30'd0, dec_op}, 32'd2);
    set_iw(1'b1, 2'd1, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12);
    for (int i = 0; i < 4; i++) cycle();
    idle(); cycle();

    // Backpressure holds outputs, pending instruction goes the cycle ready returns
    set_iw(1'b1, 2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4);
    out_ready = 1'b0;
    cycle();
    set_iw(1'b1, 2'd2, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b1;
    cycle();
    idle(); cycle();

    // Reset while busy with a held instruction and a stalled ADD pending
    set_iw(1'b1, 2'd1, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6);
    cycle();
    out_ready = 1'b0;
    set_iw(1'b1, 2'd0, 4'd8, 4'd5, 4'd9, 4'd0, 4'd0, 4'd0);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mm_en", {31'd0, mm_en}, 32'd0);
    out_ready = 1'b1;
    cycle();
    idle(); cycle();

    // Random traffic with narrow address range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_iw($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
